// File: rtl/au_cmp_eq_seq_if.sv
// Word-pair stream in, single comparison result out.
// The master side is the operand source plus the result consumer; the comparator is the slave.
interface au_cmp_eq_seq_if #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic             in_last;
    logic [WIDTH-1:0] a_word;
    logic [WIDTH-1:0] b_word;
    logic             out_valid;
    logic             out_ready;
    logic             eq;
    logic [IDX_W-1:0] mm_idx;
    logic [IDX_W-1:0] cnt;

    modport master (
        output in_valid, in_last, a_word, b_word, out_ready,
        input  in_ready, out_valid, eq, mm_idx, cnt
    );

    modport slave (
        input  in_valid, in_last, a_word, b_word, out_ready,
        output in_ready, out_valid, eq, mm_idx, cnt
    );
endinterface

// File: rtl/au_cmp_eq_seq.sv
// Sequential multi-word equality comparator: folds word-pair equality over an operand
// and returns eq, first-mismatch index and word count as one registered result.
//
//   state   | meaning
//   ST_ACC  | accepting word pairs (in_ready=1), accumulating equality
//   ST_RESP | result held on outputs (out_valid=1) until out_ready
module au_cmp_eq_seq #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    au_cmp_eq_seq_if.slave  bus
);
    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_RESP = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic             acc_eq_q, acc_eq_d;
    logic             found_q, found_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] mm_r_q, mm_r_d;
    logic             eq_q, eq_d;
    logic [IDX_W-1:0] mm_idx_q, mm_idx_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;

    logic             accept;
    logic             weq;
    logic [IDX_W-1:0] idx_inc;
    logic [IDX_W-1:0] mm_new;

    assign accept  = bus.in_valid && (state_q == ST_ACC);
    assign weq     = &(~(bus.a_word ^ bus.b_word));
    // Index sticks at all-ones so late mismatches still report a bounded position.
    assign idx_inc = (&idx_q) ? idx_q : idx_q + IDX_W'(1);
    assign mm_new  = (!weq && !found_q) ? idx_q : mm_r_q;

    always_comb begin
        state_d  = state_q;
        acc_eq_d = acc_eq_q;
        found_d  = found_q;
        idx_d    = idx_q;
        mm_r_d   = mm_r_q;
        eq_d     = eq_q;
        mm_idx_d = mm_idx_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_ACC: begin
                if (accept) begin
                    if (bus.in_last) begin
                        eq_d     = acc_eq_q & weq;
                        mm_idx_d = mm_new;
                        cnt_d    = idx_inc;
                        state_d  = ST_RESP;
                        acc_eq_d = 1'b1;
                        found_d  = 1'b0;
                        idx_d    = '0;
                        mm_r_d   = '0;
                    end else begin
                        acc_eq_d = acc_eq_q & weq;
                        found_d  = found_q | ~weq;
                        idx_d    = idx_inc;
                        mm_r_d   = mm_new;
                    end
                end
            end
            ST_RESP: begin
                if (bus.out_ready) begin
                    state_d = ST_ACC;
                end
            end
            default: state_d = ST_ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_ACC;
            acc_eq_q <= 1'b1;
            found_q  <= 1'b0;
            idx_q    <= '0;
            mm_r_q   <= '0;
            eq_q     <= 1'b0;
            mm_idx_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_eq_q <= acc_eq_d;
            found_q  <= found_d;
            idx_q    <= idx_d;
            mm_r_q   <= mm_r_d;
            eq_q     <= eq_d;
            mm_idx_q <= mm_idx_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_ACC);
    assign bus.out_valid = (state_q == ST_RESP);
    assign bus.eq        = eq_q;
    assign bus.mm_idx    = mm_idx_q;
    assign bus.cnt       = cnt_q;
endmodule
